// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: pacing/scale inputs and timing/fetch outputs of the video timing generator.
// master = the generator, slave = the framebuffer/output side that supplies pix_en and scale.
interface video_timing_gen_if #(
    parameter int ADDR_W = 19
);
    logic              pix_en;
    logic [1:0]        scale;
    logic [9:0]        hpos;
    logic [9:0]        vpos;
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              frame_start;
    logic              line_start;
    logic              vblank_irq;

    modport master (
        input  pix_en, scale,
        output hpos, vpos, fetch_en, fetch_addr, hsync, vsync, de,
        output frame_start, line_start, vblank_irq
    );

    modport slave (
        output pix_en, scale,
        input  hpos, vpos, fetch_en, fetch_addr, hsync, vsync, de,
        input  frame_start, line_start, vblank_irq
    );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised VGA/DVI sync, framebuffer fetch-address and frame/line/vblank event generator.
// Latency: fetch_addr leads hsync/vsync/de by PIPE_DLY pix_en ticks; no backpressure, pix_en only paces the timing.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIPE_DLY = 2,
    parameter int ADDR_W   = 19
) (
    input  logic               clk,
    input  logic               reset,
    video_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DLY_N   = (PIPE_DLY > 0) ? PIPE_DLY : 1;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic [ADDR_W-1:0] LINE_W1 = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_W2 = ADDR_W'(H_ACTIVE / 2);
    localparam logic [ADDR_W-1:0] LINE_W4 = ADDR_W'(H_ACTIVE / 4);

    logic [9:0]        hpos_q, hpos_d;
    logic [9:0]        vpos_q, vpos_d;
    logic [1:0]        scale_act_q, scale_act_d;
    logic              fe_q, fe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] line_w;
    logic [1:0]        rep_mask;
    logic              hs0_q, hs0_d;
    logic              vs0_q, vs0_d;
    logic              fs_q, fs_d;
    logic              ls_q, ls_d;
    logic              vb_q, vb_d;
    logic [2:0]        dly_q [DLY_N];
    logic [2:0]        tap;

    always_comb begin
        hpos_d      = hpos_q;
        vpos_d      = vpos_q;
        scale_act_d = scale_act_q;
        fe_d        = fe_q;
        addr_d      = addr_q;
        base_d      = base_q;
        hs0_d       = hs0_q;
        vs0_d       = vs0_q;
        fs_d        = 1'b0;
        ls_d        = 1'b0;
        vb_d        = 1'b0;
        rep_mask    = 2'd0;
        line_w      = LINE_W1;

        if (vif.pix_en) begin
            hpos_d = (hpos_q == H_LAST) ? 10'd0 : hpos_q + 10'd1;
            if (hpos_q == H_LAST) begin
                vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
            end
            // Replication factor only changes on the tick that starts a frame.
            if (hpos_d == 10'd0 && vpos_d == 10'd0) begin
                scale_act_d = (vif.scale == 2'd0) ? 2'd0 : ((vif.scale == 2'd1) ? 2'd1 : 2'd2);
            end
        end

        case (scale_act_d)
            2'd0:    begin rep_mask = 2'd0; line_w = LINE_W1; end
            2'd1:    begin rep_mask = 2'd1; line_w = LINE_W2; end
            default: begin rep_mask = 2'd3; line_w = LINE_W4; end
        endcase

        if (vif.pix_en) begin
            fe_d = (hpos_d < H_ACT) && (vpos_d < V_ACT);

            // Line base steps by one source line each time the low vpos bits wrap.
            if (hpos_d == 10'd0 && vpos_d < V_ACT) begin
                if (vpos_d == 10'd0) begin
                    base_d = '0;
                end else if ((vpos_d[1:0] & rep_mask) == 2'd0) begin
                    base_d = base_q + line_w;
                end
            end

            if (fe_d) begin
                if (hpos_d == 10'd0) begin
                    addr_d = base_d;
                end else if ((hpos_d[1:0] & rep_mask) == 2'd0) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            hs0_d = (hpos_d >= HS_BEG) && (hpos_d <= HS_END);
            vs0_d = (vpos_d >= VS_BEG) && (vpos_d <= VS_END);
            fs_d  = (hpos_d == 10'd0) && (vpos_d == 10'd0);
            ls_d  = (hpos_d == 10'd0) && (vpos_d < V_ACT);
            vb_d  = (hpos_d == 10'd0) && (vpos_d == V_ACT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q      <= H_LAST;
            vpos_q      <= V_LAST;
            scale_act_q <= 2'd0;
            fe_q        <= 1'b0;
            addr_q      <= '0;
            base_q      <= '0;
            hs0_q       <= 1'b0;
            vs0_q       <= 1'b0;
            fs_q        <= 1'b0;
            ls_q        <= 1'b0;
            vb_q        <= 1'b0;
            for (int i = 0; i < DLY_N; i++) begin
                dly_q[i] <= 3'b000;
            end
        end else begin
            hpos_q      <= hpos_d;
            vpos_q      <= vpos_d;
            scale_act_q <= scale_act_d;
            fe_q        <= fe_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            hs0_q       <= hs0_d;
            vs0_q       <= vs0_d;
            fs_q        <= fs_d;
            ls_q        <= ls_d;
            vb_q        <= vb_d;
            if (vif.pix_en) begin
                dly_q[0] <= {hs0_q, vs0_q, fe_q};
                for (int i = 1; i < DLY_N; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end
    end

    // Delay-line entries hold unpolarised {hsync, vsync, de} activity flags.
    assign tap = (PIPE_DLY == 0) ? {hs0_q, vs0_q, fe_q} : dly_q[DLY_N-1];

    assign vif.hpos        = hpos_q;
    assign vif.vpos        = vpos_q;
    assign vif.fetch_en    = fe_q;
    assign vif.fetch_addr  = addr_q;
    assign vif.hsync       = tap[2] ? HS_POL : ~HS_POL;
    assign vif.vsync       = tap[1] ? VS_POL : ~VS_POL;
    assign vif.de          = tap[0];
    assign vif.frame_start = fs_q;
    assign vif.line_start  = ls_q;
    assign vif.vblank_irq  = vb_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a shrunken 16x12 raster: table of checkpoints plus
// hand sequences for pix_en pacing, mid-frame scale change and mid-frame reset.
module tb_video_timing_gen;
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HB  = 3;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int HT  = HA + HFP + HS + HB;
    localparam int VT  = VA + VFP + VS + VB;
    localparam int PD  = 2;
    localparam int AW  = 8;
    localparam int NV  = 20;

    typedef struct packed {
        logic [9:0]    hpos;
        logic [9:0]    vpos;
        logic          fe;
        logic [AW-1:0] addr;
        logic          hs;
        logic          vs;
        logic          de;
        logic          fs;
        logic          ls;
        logic          vb;
    } obs_t;

    typedef struct {
        int         n;
        logic [1:0] sc;
        obs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    video_timing_gen_if #(.ADDR_W(AW)) vif ();

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_DLY(PD), .ADDR_W(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   m_h, m_v, m_s, m_addr;
    logic m_fe, m_fs, m_ls, m_vb;
    logic [2:0] m_hist [0:PD];
    obs_t m_exp;
    obs_t sb_q [$];
    vec_t tbl [NV];
    int   fs_at [$];

    function automatic obs_t mk(int h, int v, bit fe, int addr, bit hs, bit vs, bit de,
                                bit fs, bit ls, bit vb);
        obs_t o;
        o.hpos = 10'(h); o.vpos = 10'(v); o.fe = fe; o.addr = AW'(addr);
        o.hs = hs; o.vs = vs; o.de = de; o.fs = fs; o.ls = ls; o.vb = vb;
        return o;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o.hpos = vif.hpos; o.vpos = vif.vpos; o.fe = vif.fetch_en; o.addr = vif.fetch_addr;
        o.hs = vif.hsync; o.vs = vif.vsync; o.de = vif.de;
        o.fs = vif.frame_start; o.ls = vif.line_start; o.vb = vif.vblank_irq;
        return o;
    endfunction

    task automatic build_exp();
        m_exp.hpos = 10'(m_h);
        m_exp.vpos = 10'(m_v);
        m_exp.fe   = m_fe;
        m_exp.addr = AW'(m_addr);
        m_exp.hs   = ~m_hist[PD][2];   // hsync active-low
        m_exp.vs   = m_hist[PD][1];    // vsync active-high in this bench
        m_exp.de   = m_hist[PD][0];
        m_exp.fs   = m_fs;
        m_exp.ls   = m_ls;
        m_exp.vb   = m_vb;
    endtask

    task automatic model_reset();
        m_h = HT - 1; m_v = VT - 1; m_s = 0; m_addr = 0;
        m_fe = 1'b0; m_fs = 1'b0; m_ls = 1'b0; m_vb = 1'b0;
        for (int i = 0; i <= PD; i++) m_hist[i] = 3'b000;
        build_exp();
    endtask

    task automatic model_tick(input bit pen, input logic [1:0] sc);
        m_fs = 1'b0; m_ls = 1'b0; m_vb = 1'b0;
        if (pen) begin
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v++;
                if (m_v == VT) m_v = 0;
            end
            if (m_h == 0 && m_v == 0) m_s = (sc == 2'd0) ? 0 : ((sc == 2'd1) ? 1 : 2);
            m_fe = (m_h < HA) && (m_v < VA);
            if (m_fe) m_addr = (m_v >> m_s) * (HA >> m_s) + (m_h >> m_s);
            for (int i = PD; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = {(m_h >= HA + HFP) && (m_h < HA + HFP + HS),
                         (m_v >= VA + VFP) && (m_v < VA + VFP + VS), m_fe};
            m_fs = (m_h == 0) && (m_v == 0);
            m_ls = (m_h == 0) && (m_v < VA);
            m_vb = (m_h == 0) && (m_v == VA);
        end
        build_exp();
    endtask

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = sample_dut();
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: actual h=%0d v=%0d fe=%b addr=%0d hs=%b vs=%b de=%b fs=%b ls=%b vb=%b | expected h=%0d v=%0d fe=%b addr=%0d hs=%b vs=%b de=%b fs=%b ls=%b vb=%b",
                     name, $time, act.hpos, act.vpos, act.fe, act.addr, act.hs, act.vs, act.de,
                     act.fs, act.ls, act.vb, exp.hpos, exp.vpos, exp.fe, exp.addr, exp.hs, exp.vs,
                     exp.de, exp.fs, exp.ls, exp.vb);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: actual %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] sc);
        @(negedge clk);
        #2;
        reset = 1'b1;
        vif.pix_en = 1'b0;
        vif.scale = sc;
        model_reset();
        #1 check("reset_async", m_exp);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cycle(input bit pen, input logic [1:0] sc);
        obs_t e;
        @(negedge clk);
        vif.pix_en = pen;
        vif.scale = sc;
        model_tick(pen, sc);
        sb_q.push_back(m_exp);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb", e);
    endtask

    initial begin
        vif.pix_en = 1'b0;
        vif.scale = 2'd0;
        model_reset();

        //                        n    sc    h   v fe addr hs vs de fs ls vb
        tbl[0]  = '{n: 0,   sc: 2'd0, exp: mk(15, 11, 0,  0, 1, 0, 0, 0, 0, 0)};
        tbl[1]  = '{n: 1,   sc: 2'd0, exp: mk( 0,  0, 1,  0, 1, 0, 0, 1, 1, 0)};
        tbl[2]  = '{n: 2,   sc: 2'd0, exp: mk( 1,  0, 1,  1, 1, 0, 0, 0, 0, 0)};
        tbl[3]  = '{n: 3,   sc: 2'd0, exp: mk( 2,  0, 1,  2, 1, 0, 1, 0, 0, 0)};
        tbl[4]  = '{n: 12,  sc: 2'd0, exp: mk(11,  0, 0,  7, 1, 0, 0, 0, 0, 0)};
        tbl[5]  = '{n: 13,  sc: 2'd0, exp: mk(12,  0, 0,  7, 0, 0, 0, 0, 0, 0)};
        tbl[6]  = '{n: 15,  sc: 2'd0, exp: mk(14,  0, 0,  7, 0, 0, 0, 0, 0, 0)};
        tbl[7]  = '{n: 16,  sc: 2'd0, exp: mk(15,  0, 0,  7, 1, 0, 0, 0, 0, 0)};
        tbl[8]  = '{n: 17,  sc: 2'd0, exp: mk( 0,  1, 1,  8, 1, 0, 0, 0, 1, 0)};
        tbl[9]  = '{n: 120, sc: 2'd0, exp: mk( 7,  7, 1, 63, 1, 0, 1, 0, 0, 0)};
        tbl[10] = '{n: 129, sc: 2'd0, exp: mk( 0,  8, 0, 63, 1, 0, 0, 0, 0, 1)};
        tbl[11] = '{n: 145, sc: 2'd0, exp: mk( 0,  9, 0, 63, 1, 0, 0, 0, 0, 0)};
        tbl[12] = '{n: 147, sc: 2'd0, exp: mk( 2,  9, 0, 63, 1, 1, 0, 0, 0, 0)};
        tbl[13] = '{n: 193, sc: 2'd0, exp: mk( 0,  0, 1,  0, 1, 0, 0, 1, 1, 0)};
        tbl[14] = '{n: 54,  sc: 2'd1, exp: mk( 5,  3, 1,  6, 1, 0, 1, 0, 0, 0)};
        tbl[15] = '{n: 33,  sc: 2'd1, exp: mk( 0,  2, 1,  4, 1, 0, 0, 0, 1, 0)};
        tbl[16] = '{n: 56,  sc: 2'd1, exp: mk( 7,  3, 1,  7, 1, 0, 1, 0, 0, 0)};
        tbl[17] = '{n: 120, sc: 2'd2, exp: mk( 7,  7, 1,  3, 1, 0, 1, 0, 0, 0)};
        tbl[18] = '{n: 69,  sc: 2'd3, exp: mk( 4,  4, 1,  3, 1, 0, 1, 0, 0, 0)};
        tbl[19] = '{n: 68,  sc: 2'd3, exp: mk( 3,  4, 1,  2, 1, 0, 1, 0, 0, 0)};

        for (int i = 0; i < NV; i++) begin
            do_reset(tbl[i].sc);
            repeat (tbl[i].n) cycle(1'b1, tbl[i].sc);
            check($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // pix_en every other clk: frame period doubles, pulses stay one clk wide.
        do_reset(2'd0);
        for (int c = 0; c < 4 * HT * VT + 8; c++) begin
            cycle((c % 2) == 0, 2'd0);
            if (vif.frame_start) fs_at.push_back(c);
        end
        check_int("fs_seen", (fs_at.size() >= 2) ? 1 : 0, 1);
        if (fs_at.size() >= 2) check_int("frame_period_half_rate", fs_at[1] - fs_at[0], 2 * HT * VT);

        // Scale switched 0->2 mid-frame takes effect only at the next frame.
        do_reset(2'd0);
        repeat (65) cycle(1'b1, 2'd0);
        repeat (5) cycle(1'b1, 2'd2);
        check_int("scale_mid_frame_addr", int'(vif.fetch_addr), 37);
        repeat (146) cycle(1'b1, 2'd2);
        check_int("scale_next_frame_addr", int'(vif.fetch_addr), 1);
        repeat (50) cycle(1'b1, 2'd2);

        // Reset mid-frame, then restart at (0,0) with a freshly sampled scale.
        do_reset(2'd0);
        repeat (102) cycle(1'b1, 2'd0);
        check_int("pre_reset_hpos", int'(vif.hpos), 5);
        do_reset(2'd1);
        cycle(1'b1, 2'd1);
        check_int("restart_frame_start", int'(vif.frame_start), 1);
        cycle(1'b0, 2'd1);
        check_int("restart_frame_start_width", int'(vif.frame_start), 0);
        repeat (53) cycle(1'b1, 2'd1);
        check_int("restart_scale1_addr", int'(vif.fetch_addr), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised VGA/DVI timing generator. Generalises the fixed 640x480 sync generator with:
- configurable timings and sync polarities
- a pixel clock-enable input
- runtime pixel replication (1x/2x/4x)
- a framebuffer fetch address with a programmable fetch-to-pixel pipeline delay
- frame, line and vblank event pulses

It sits between the framebuffer read port and the video output pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, active level of hsync (0 = active-low)
VS_POL, 0, active level of vsync
PIPE_DLY, 2, pix_en ticks from fetch_addr to matching hsync/vsync/de (range 0..15)
ADDR_W, 19, width of fetch_addr

Ports:
clk  in  1  pixel-domain clock
reset  in  1  asynchronous, active-high reset
pix_en  in  1  pixel tick; all timing state advances only on clk edges where pix_en=1
scale  in  2  replication: 0=1x, 1=2x, 2=4x, 3 treated as 4x
hpos  out  10  stage-0 horizontal counter
vpos  out  10  stage-0 vertical counter
fetch_en  out  1  stage-0 active-area flag
fetch_addr  out  ADDR_W  stage-0 framebuffer word address
hsync  out  1  delayed horizontal sync
vsync  out  1  delayed vertical sync
de  out  1  delayed data enable
frame_start  out  1  one-clk pulse
line_start  out  1  one-clk pulse
vblank_irq  out  1  one-clk pulse

Behaviour:
- Totals and regions:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL likewise.
  - Line order: active, front porch, sync, back porch.
  - hsync region (stage 0): hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync region analogous on vpos.
- Reset values (async):
  - hpos = H_TOTAL-1, vpos = V_TOTAL-1
  - fetch_en = 0, fetch_addr = 0, de = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - all pulses 0; delay line filled with inactive levels
  - scale_active = 0
- Counters, on each pix_en tick:
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps at V_TOTAL-1.
  - The first tick after reset reaches (0,0).
  - With pix_en=0, all state holds; pulses are still one clk only.
- Scale latch:
  - scale is sampled into scale_active (s) only on the tick that enters (0,0).
  - A mid-frame change has no effect until the next frame.
- Fetch (stage 0, registered together with hpos/vpos):
  - fetch_en = (hpos < H_ACTIVE) && (vpos < V_ACTIVE).
  - When fetch_en=1: fetch_addr = (vpos>>s)*(H_ACTIVE>>s) + (hpos>>s).
  - Implementation: incremental line-base and pixel counters; no multiplier.
  - Each source line repeats 2^s times; each pixel repeats 2^s ticks.
  - fetch_addr holds its last value while fetch_en=0.
  - H_ACTIVE and V_ACTIVE must be divisible by 4.
- Output delay:
  - Stage-0 sync/de values pass through a PIPE_DLY-deep shift register that advances only on pix_en.
  - hsync/vsync are driven at polarity HS_POL/VS_POL.
  - PIPE_DLY=0 means outputs are combinational from stage 0 (registered, same tick).
- Pulses, each high for exactly one clk, in the clk after the tick that causes the event:
  - frame_start: counters entered (0,0).
  - line_start: hpos entered 0 with the new vpos < V_ACTIVE.
  - vblank_irq: counters entered (0, V_ACTIVE).
- Simultaneous events: frame_start and line_start both assert on (0,0).
- Reset mid-frame: immediate return to reset values; the next tick starts a fresh frame at (0,0) with a newly sampled scale.

Test Plan:
- Defaults, pix_en=1, scale=0: stage-0 hsync region is hpos 656..751; the hsync pin is low from tick 2 after hpos=656 to tick 2 after hpos=751. Frame period is exactly 420000 clks.
- Defaults, scale=0: at (hpos=639, vpos=479) fetch_addr=307199; de rises 2 ticks after fetch_en rises.
- scale=1: at (hpos=5, vpos=3) fetch_addr=322; vpos 2 and 3 produce identical address sequences 320..639.
- pix_en toggling 1,0,1,0: counters advance every other clk; frame period 840000 clks; each pulse still lasts one clk.
- scale switched 0->2 at vpos=100: addresses in the current frame are unchanged; the next frame reads 0..159 per line, each address held 4 ticks.
- reset asserted at (300, 200): all outputs take reset values immediately; after release, the first tick gives hpos=0, vpos=0 and frame_start=1 for one clk.
